// File: rtl/mips_bus_pkg.sv
// Shared types for the MIPS32 unified memory-port arbiter.
// Holds the arbiter state/owner enums, the default bus widths used by the
// core, and the fixed-priority pick function.
package mips_bus_pkg;

    localparam int MIPS_ADDR_W = 32;
    localparam int MIPS_DATA_W = 32;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } arb_state_t;

    typedef enum logic {
        OWN_I = 1'b0,
        OWN_D = 1'b1
    } owner_t;

    // D beats I unless the starvation guard forces an I win.
    function automatic owner_t arb_pick(input logic d_req, input logic force_i);
        return (d_req && !force_i) ? OWN_D : OWN_I;
    endfunction

endpackage

// File: rtl/arb_starve_counter.sv
// Starvation guard for the fetch requester: counts consecutive D grants made
// while i_req is pending and raises force_i once MAX_WAIT is reached.
// Only instantiated when ARB_STARVE_GUARD_EN is defined.
module arb_starve_counter #(
    parameter int MAX_WAIT = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic i_req,
    input  logic d_win,
    input  logic i_win,
    output logic force_i
);

    localparam int CNT_W = $clog2(MAX_WAIT + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_WAIT);

    logic [CNT_W-1:0] count;

    // Count D wins against a waiting I; any I win or a dropped i_req restarts it.
    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else if (i_win || !i_req) begin
            count <= '0;
        end else if (d_win && (count != CNT_MAX)) begin
            count <= count + 1'b1;
        end
    end

    assign force_i = i_req && (count == CNT_MAX);

endmodule

// File: rtl/mem_bus_arbiter.sv
// Arbiter sharing the single unified memory port between instruction fetch (I)
// and load/store (D). One transaction outstanding at a time, sequenced by a
// 4-state FSM (IDLE/ISSUE/WAIT/RESP). All outputs are registered.
// Optional feature macro: ARB_STARVE_GUARD_EN (fetch starvation guard).
//
// Handshakes: a requester raises *_req with stable fields and holds it until
// it sees its one-cycle *_gnt; requests are only sampled in IDLE. Towards
// memory, m_req and its fields stay stable until m_ack is seen; read data
// arrives later as a single m_rvalid beat. Responses to requesters are a
// single *_rvalid pulse with no back-pressure.
module mem_bus_arbiter
    import mips_bus_pkg::*;
#(
    parameter int ADDR_W   = MIPS_ADDR_W,
    parameter int DATA_W   = MIPS_DATA_W,
    parameter int MAX_WAIT = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                i_req,
    input  logic [ADDR_W-1:0]   i_addr,
    output logic                i_gnt,
    output logic                i_rvalid,
    output logic [DATA_W-1:0]   i_rdata,
    input  logic                d_req,
    input  logic                d_we,
    input  logic [DATA_W/8-1:0] d_be,
    input  logic [ADDR_W-1:0]   d_addr,
    input  logic [DATA_W-1:0]   d_wdata,
    output logic                d_gnt,
    output logic                d_rvalid,
    output logic [DATA_W-1:0]   d_rdata,
    output logic                m_req,
    output logic                m_we,
    output logic [DATA_W/8-1:0] m_be,
    output logic [ADDR_W-1:0]   m_addr,
    output logic [DATA_W-1:0]   m_wdata,
    input  logic                m_ack,
    input  logic                m_rvalid,
    input  logic [DATA_W-1:0]   m_rdata,
    output logic                busy
);

    if (MAX_WAIT < 1) begin : g_bad_max_wait
        $error("mem_bus_arbiter: MAX_WAIT must be at least 1");
    end

    // FSM state and transaction owner; state is the name checkers bind to.
    arb_state_t state;
    owner_t     owner;

    logic   any_req;
    logic   force_i;
    owner_t win;

    assign any_req = i_req || d_req;
    assign win     = arb_pick(d_req, force_i);

`ifdef ARB_STARVE_GUARD_EN
    logic d_win;
    logic i_win;

    assign d_win = (state == IDLE) && any_req && (win == OWN_D);
    assign i_win = (state == IDLE) && any_req && (win == OWN_I);

    arb_starve_counter #(
        .MAX_WAIT (MAX_WAIT)
    ) u_starve (
        .clk     (clk),
        .rst     (rst),
        .i_req   (i_req),
        .d_win   (d_win),
        .i_win   (i_win),
        .force_i (force_i)
    );
`else
    assign force_i = 1'b0;
`endif

    // Transaction sequencer: arbitrate in IDLE, hold the memory request in
    // ISSUE until acked, collect read data in WAIT, signal store completion
    // in RESP. Pulse outputs default low every cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            owner    <= OWN_I;
            i_gnt    <= 1'b0;
            i_rvalid <= 1'b0;
            i_rdata  <= '0;
            d_gnt    <= 1'b0;
            d_rvalid <= 1'b0;
            d_rdata  <= '0;
            m_req    <= 1'b0;
            m_we     <= 1'b0;
            m_be     <= '0;
            m_addr   <= '0;
            m_wdata  <= '0;
            busy     <= 1'b0;
        end else begin
            i_gnt    <= 1'b0;
            d_gnt    <= 1'b0;
            i_rvalid <= 1'b0;
            d_rvalid <= 1'b0;
            case (state)
                IDLE: begin
                    if (any_req) begin
                        owner <= win;
                        m_req <= 1'b1;
                        busy  <= 1'b1;
                        state <= ISSUE;
                        if (win == OWN_D) begin
                            d_gnt   <= 1'b1;
                            m_we    <= d_we;
                            m_be    <= d_be;
                            m_addr  <= d_addr;
                            m_wdata <= d_wdata;
                        end else begin
                            // Fetches are always full-word reads.
                            i_gnt   <= 1'b1;
                            m_we    <= 1'b0;
                            m_be    <= '1;
                            m_addr  <= i_addr;
                            m_wdata <= '0;
                        end
                    end
                end
                ISSUE: begin
                    if (m_ack) begin
                        m_req <= 1'b0;
                        if (m_we) begin
                            // Store completion is raised on entry so it is
                            // visible during the RESP cycle itself.
                            d_rvalid <= 1'b1;
                            d_rdata  <= '0;
                            state    <= RESP;
                        end else begin
                            state <= WAIT;
                        end
                    end
                end
                WAIT: begin
                    if (m_rvalid) begin
                        if (owner == OWN_D) begin
                            d_rvalid <= 1'b1;
                            d_rdata  <= m_rdata;
                        end else begin
                            i_rvalid <= 1'b1;
                            i_rdata  <= m_rdata;
                        end
                        busy  <= 1'b0;
                        state <= IDLE;
                    end
                end
                RESP: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

    // Memory protocol violations: responses outside the phase expecting them.
    a_rvalid_in_wait: assert property (@(posedge clk) disable iff (rst)
        m_rvalid |-> (state == WAIT));
    a_ack_in_issue: assert property (@(posedge clk) disable iff (rst)
        m_ack |-> (state == ISSUE));

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed bench for mem_bus_arbiter: reset values, a table of single
// transactions, then hand-written contention, stall, reset-mid-WAIT and
// starvation sequences against a small memory responder.
module tb_mem_bus_arbiter;

  logic        clk;
  logic        rst;
  logic        i_req;
  logic [31:0] i_addr;
  logic        i_gnt;
  logic        i_rvalid;
  logic [31:0] i_rdata;
  logic        d_req;
  logic        d_we;
  logic [3:0]  d_be;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic        d_gnt;
  logic        d_rvalid;
  logic [31:0] d_rdata;
  logic        m_req;
  logic        m_we;
  logic [3:0]  m_be;
  logic [31:0] m_addr;
  logic [31:0] m_wdata;
  logic        m_ack;
  logic        m_rvalid;
  logic [31:0] m_rdata;
  logic        busy;

  int n_cmp = 0;
  int n_err = 0;

  mem_bus_arbiter #(
    .ADDR_W   (32),
    .DATA_W   (32),
    .MAX_WAIT (4)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .i_req    (i_req),
    .i_addr   (i_addr),
    .i_gnt    (i_gnt),
    .i_rvalid (i_rvalid),
    .i_rdata  (i_rdata),
    .d_req    (d_req),
    .d_we     (d_we),
    .d_be     (d_be),
    .d_addr   (d_addr),
    .d_wdata  (d_wdata),
    .d_gnt    (d_gnt),
    .d_rvalid (d_rvalid),
    .d_rdata  (d_rdata),
    .m_req    (m_req),
    .m_we     (m_we),
    .m_be     (m_be),
    .m_addr   (m_addr),
    .m_wdata  (m_wdata),
    .m_ack    (m_ack),
    .m_rvalid (m_rvalid),
    .m_rdata  (m_rdata),
    .busy     (busy)
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- memory responder ----------------
  // Acks m_req after ack_stall cycles; read data follows rd_gap cycles
  // after the ack cycle. Drives 2 time units after the rising edge.
  int          ack_stall = 0;
  int          rd_gap = 2;
  logic [31:0] mem_data_next = 32'h0;
  int          wait_cnt = 0;
  int          rd_cnt = 0;
  bit          rd_pending = 1'b0;
  logic [31:0] rd_word = 32'h0;

  initial begin
    m_ack = 1'b0;
    m_rvalid = 1'b0;
    m_rdata = 32'h0;
    forever begin
      @(posedge clk);
      #2;
      m_ack = 1'b0;
      m_rvalid = 1'b0;
      m_rdata = 32'h0;
      if (rst) begin
        rd_pending = 1'b0;
        wait_cnt = 0;
      end else if (rd_pending) begin
        if (rd_cnt == 0) begin
          m_rvalid = 1'b1;
          m_rdata = rd_word;
          rd_pending = 1'b0;
        end else begin
          rd_cnt = rd_cnt - 1;
        end
      end else if (m_req) begin
        if (wait_cnt >= ack_stall) begin
          m_ack = 1'b1;
          wait_cnt = 0;
          if (!m_we) begin
            rd_pending = 1'b1;
            rd_cnt = rd_gap - 1;
            rd_word = mem_data_next;
          end
        end else begin
          wait_cnt = wait_cnt + 1;
        end
      end
    end
  end

  // ---------------- driver / checker tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic chk_all_zero(input string pfx);
    chk({pfx, "_i_gnt"},    i_gnt,    0);
    chk({pfx, "_d_gnt"},    d_gnt,    0);
    chk({pfx, "_i_rvalid"}, i_rvalid, 0);
    chk({pfx, "_d_rvalid"}, d_rvalid, 0);
    chk({pfx, "_i_rdata"},  i_rdata,  0);
    chk({pfx, "_d_rdata"},  d_rdata,  0);
    chk({pfx, "_m_req"},    m_req,    0);
    chk({pfx, "_m_we"},     m_we,     0);
    chk({pfx, "_m_be"},     m_be,     0);
    chk({pfx, "_m_addr"},   m_addr,   0);
    chk({pfx, "_m_wdata"},  m_wdata,  0);
    chk({pfx, "_busy"},     busy,     0);
  endtask

  // Steps until the selected rvalid is seen; lat counts steps taken.
  task automatic wait_rv(input string name, input bit is_d, input int max_cyc, output int lat);
    lat = 0;
    while (1) begin
      step();
      lat++;
      if (is_d ? d_rvalid : i_rvalid) break;
      if (lat >= max_cyc) begin
        n_cmp++;
        n_err++;
        $display("FAIL %s_timeout: no rvalid within %0d cycles", name, max_cyc);
        break;
      end
    end
  endtask

  task automatic wait_idle(input string name, input int max_cyc);
    int c;
    c = 0;
    while (busy) begin
      step();
      c++;
      if (c >= max_cyc) begin
        n_cmp++;
        n_err++;
        $display("FAIL %s_idle_timeout: busy still 1 after %0d cycles", name, max_cyc);
        break;
      end
    end
  endtask

  // ---------------- directed vectors ----------------
  typedef struct {
    bit          is_d;
    bit          we;
    logic [3:0]  be;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] mem_data;
    bit          exp_we;
    logic [3:0]  exp_be;
    logic [31:0] exp_wdata;
    int          exp_lat;
    logic [31:0] exp_rdata;
    bit          exp_busy_rv;
  } vec_t;

  vec_t vecs[6];

  initial begin
    int lat;
    int gcnt;
    bit owners[5];
    bit exp_owners[5];

    rst = 1'b1;
    i_req = 1'b0;
    i_addr = 32'h0;
    d_req = 1'b0;
    d_we = 1'b0;
    d_be = 4'h0;
    d_addr = 32'h0;
    d_wdata = 32'h0;

    //               is_d we  be     addr           wdata          mem_data       e_we e_be   e_wdata        lat rdata          busy
    vecs[0] = '{1'b0, 1'b0, 4'hF, 32'h0000_0040, 32'hAAAA_5555, 32'h2408_0005, 1'b0, 4'hF, 32'h0000_0000, 3, 32'h2408_0005, 1'b0};
    vecs[1] = '{1'b1, 1'b1, 4'h3, 32'h0000_0100, 32'hDEAD_BEEF, 32'h1111_1111, 1'b1, 4'h3, 32'hDEAD_BEEF, 1, 32'h0000_0000, 1'b1};
    vecs[2] = '{1'b1, 1'b0, 4'hF, 32'h0000_0200, 32'h1234_5678, 32'hCAFE_F00D, 1'b0, 4'hF, 32'h1234_5678, 3, 32'hCAFE_F00D, 1'b0};
    vecs[3] = '{1'b0, 1'b1, 4'h1, 32'hFFFF_FFFC, 32'h5A5A_5A5A, 32'hFFFF_FFFF, 1'b0, 4'hF, 32'h0000_0000, 3, 32'hFFFF_FFFF, 1'b0};
    vecs[4] = '{1'b1, 1'b1, 4'h8, 32'h0000_0004, 32'h0000_0000, 32'h0BAD_F00D, 1'b1, 4'h8, 32'h0000_0000, 1, 32'h0000_0000, 1'b1};
    vecs[5] = '{1'b1, 1'b0, 4'h4, 32'h0000_07FC, 32'h0000_0000, 32'h00FF_00FF, 1'b0, 4'h4, 32'h0000_0000, 3, 32'h00FF_00FF, 1'b0};

    // ---- reset ----
    step();
    step();
    chk_all_zero("reset");
    rst = 1'b0;
    step();

    // ---- table: one transaction per vector ----
    foreach (vecs[k]) begin
      mem_data_next = vecs[k].mem_data;
      d_we = vecs[k].we;
      d_be = vecs[k].be;
      d_addr = vecs[k].addr;
      d_wdata = vecs[k].wdata;
      i_addr = vecs[k].addr;
      if (vecs[k].is_d) d_req = 1'b1;
      else i_req = 1'b1;
      step();
      chk($sformatf("v%0d_i_gnt", k), i_gnt, !vecs[k].is_d);
      chk($sformatf("v%0d_d_gnt", k), d_gnt, vecs[k].is_d);
      chk($sformatf("v%0d_m_req", k), m_req, 1);
      chk($sformatf("v%0d_m_we", k), m_we, vecs[k].exp_we);
      chk($sformatf("v%0d_m_be", k), m_be, vecs[k].exp_be);
      chk($sformatf("v%0d_m_addr", k), m_addr, vecs[k].addr);
      chk($sformatf("v%0d_m_wdata", k), m_wdata, vecs[k].exp_wdata);
      chk($sformatf("v%0d_busy_issue", k), busy, 1);
      i_req = 1'b0;
      d_req = 1'b0;
      wait_rv($sformatf("v%0d", k), vecs[k].is_d, 20, lat);
      chk($sformatf("v%0d_latency", k), lat, vecs[k].exp_lat);
      if (vecs[k].is_d) begin
        chk($sformatf("v%0d_d_rdata", k), d_rdata, vecs[k].exp_rdata);
        chk($sformatf("v%0d_i_rvalid", k), i_rvalid, 0);
      end else begin
        chk($sformatf("v%0d_i_rdata", k), i_rdata, vecs[k].exp_rdata);
        chk($sformatf("v%0d_d_rvalid", k), d_rvalid, 0);
      end
      chk($sformatf("v%0d_busy_rv", k), busy, vecs[k].exp_busy_rv);
      wait_idle($sformatf("v%0d", k), 20);
      step();
    end

    // ---- contention: D store and I fetch in the same IDLE cycle ----
    d_we = 1'b1;
    d_be = 4'hF;
    d_addr = 32'h0000_0A00;
    d_wdata = 32'h0102_0304;
    i_addr = 32'h0000_0B00;
    mem_data_next = 32'h8C42_0000;
    d_req = 1'b1;
    i_req = 1'b1;
    step();
    chk("cont_d_gnt_first", d_gnt, 1);
    chk("cont_i_gnt_first", i_gnt, 0);
    chk("cont_m_addr_d", m_addr, 32'h0000_0A00);
    d_req = 1'b0;
    step();
    chk("cont_store_done", d_rvalid, 1);
    step();
    chk("cont_idle_gap_busy", busy, 0);
    chk("cont_idle_gap_i_gnt", i_gnt, 0);
    step();
    chk("cont_i_gnt_after", i_gnt, 1);
    chk("cont_m_addr_i", m_addr, 32'h0000_0B00);
    i_req = 1'b0;
    wait_rv("cont_i", 1'b0, 20, lat);
    chk("cont_i_latency", lat, 3);
    chk("cont_i_rdata", i_rdata, 32'h8C42_0000);
    wait_idle("cont", 20);
    step();

    // ---- memory stall: no ack for 5 cycles ----
    ack_stall = 5;
    i_addr = 32'h0000_0500;
    mem_data_next = 32'h3C01_1234;
    i_req = 1'b1;
    step();
    i_req = 1'b0;
    for (int s = 0; s < 5; s++) begin
      chk($sformatf("stall%0d_m_req", s), m_req, 1);
      chk($sformatf("stall%0d_m_addr", s), m_addr, 32'h0000_0500);
      chk($sformatf("stall%0d_i_gnt", s), i_gnt, (s == 0));
      chk($sformatf("stall%0d_busy", s), busy, 1);
      step();
    end
    wait_rv("stall", 1'b0, 20, lat);
    chk("stall_latency", lat, 3);
    chk("stall_i_rdata", i_rdata, 32'h3C01_1234);
    ack_stall = 0;
    wait_idle("stall", 20);
    step();

    // ---- reset while in WAIT ----
    rd_gap = 6;
    i_addr = 32'h0000_0600;
    mem_data_next = 32'hFACE_CAFE;
    i_req = 1'b1;
    step();
    chk("rstw_i_gnt", i_gnt, 1);
    i_req = 1'b0;
    step();
    chk("rstw_busy_wait", busy, 1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk_all_zero("rstw");
    rd_gap = 2;
    i_addr = 32'h0000_0604;
    mem_data_next = 32'h0F0F_0F0F;
    i_req = 1'b1;
    step();
    chk("rstw_fresh_i_gnt", i_gnt, 1);
    chk("rstw_fresh_m_addr", m_addr, 32'h0000_0604);
    i_req = 1'b0;
    wait_rv("rstw_fresh", 1'b0, 20, lat);
    chk("rstw_fresh_latency", lat, 3);
    chk("rstw_fresh_i_rdata", i_rdata, 32'h0F0F_0F0F);
    wait_idle("rstw", 20);
    step();

    // ---- starvation: i_req held while d_req stays high ----
`ifdef ARB_STARVE_GUARD_EN
    exp_owners = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
`else
    exp_owners = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
`endif
    mem_data_next = 32'h0000_1111;
    d_we = 1'b0;
    d_be = 4'hF;
    d_addr = 32'h0000_0300;
    i_addr = 32'h0000_0080;
    d_req = 1'b1;
    i_req = 1'b1;
    gcnt = 0;
    for (int c = 0; c < 200 && gcnt < 5; c++) begin
      step();
      if (d_gnt) begin
        owners[gcnt] = 1'b1;
        gcnt++;
      end else if (i_gnt) begin
        owners[gcnt] = 1'b0;
        gcnt++;
        i_req = 1'b0;
      end
    end
    d_req = 1'b0;
    i_req = 1'b0;
    chk("starve_grant_count", gcnt, 5);
    for (int g = 0; g < 5; g++) begin
      chk($sformatf("starve_grant%0d_is_d", g), owners[g], exp_owners[g]);
    end
    wait_idle("starve", 20);
    step();
    chk("final_busy", busy, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
